// File: rtl/pc_unit.sv
// Program-counter unit: holds the architectural PC, forms sequential and redirect
// targets, arbitrates trap/stall/redirect, and counts retired instructions.
module pc_unit #(
   parameter int unsigned           XLEN         = 32,
   parameter logic [XLEN-1:0]       RESET_VECTOR = '0,
   parameter bit                    C_EXT        = 1'b0,
   parameter int unsigned           CNT_W        = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic              jump,
   input  logic              jalr,
   input  logic [XLEN-1:0]   rs1,
   input  logic [XLEN-1:0]   imm,
   input  logic              insn_compressed,
   input  logic              trap,
   input  logic [XLEN-1:0]   trap_target,
   output logic [XLEN-1:0]   pc_current,
   output logic [XLEN-1:0]   pc_next_seq,
   output logic [XLEN-1:0]   pc_target,
   output logic              flush,
   output logic              misaligned,
   output logic [XLEN-1:0]   misaligned_addr,
   output logic [CNT_W-1:0]  instret
);

   localparam logic [XLEN-1:0] INC_FULL  = XLEN'(4);
   localparam logic [XLEN-1:0] INC_HALF  = XLEN'(2);
   localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);
   localparam logic [XLEN-1:0] TRAP_MASK = ~XLEN'(3);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic             flush_q, flush_d;
   logic             mis_q, mis_d;
   logic [XLEN-1:0]  mis_addr_q, mis_addr_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic [XLEN-1:0]  inc;
   logic [XLEN-1:0]  jalr_sum;
   logic             redir;
   logic             tgt_misaligned;

   // Sequential and redirect target arithmetic, modulo 2^XLEN.
   always_comb begin
      inc         = (C_EXT && insn_compressed) ? INC_HALF : INC_FULL;
      pc_next_seq = pc_q + inc;
      jalr_sum    = rs1 + imm;
      pc_target   = jalr ? (jalr_sum & JALR_MASK) : (pc_q + imm);
      redir       = branch_taken | jump;
      tgt_misaligned = C_EXT ? pc_target[0] : (pc_target[1:0] != 2'b00);
   end

   // Next-state selection: trap > stall > misaligned redirect > redirect > sequential.
   always_comb begin
      pc_d       = pc_q;
      flush_d    = 1'b0;
      mis_d      = 1'b0;
      mis_addr_d = mis_addr_q;
      instret_d  = instret_q;
      if (trap) begin
         pc_d    = trap_target & TRAP_MASK;
         flush_d = 1'b1;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (redir && tgt_misaligned) begin
         mis_d      = 1'b1;
         mis_addr_d = pc_target;
      end else if (redir) begin
         pc_d      = pc_target;
         flush_d   = 1'b1;
         instret_d = instret_q + CNT_W'(1);
      end else begin
         pc_d      = pc_next_seq;
         instret_d = instret_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VECTOR;
         flush_q    <= 1'b0;
         mis_q      <= 1'b0;
         mis_addr_q <= '0;
         instret_q  <= '0;
      end else begin
         pc_q       <= pc_d;
         flush_q    <= flush_d;
         mis_q      <= mis_d;
         mis_addr_q <= mis_addr_d;
         instret_q  <= instret_d;
      end
   end

   assign pc_current      = pc_q;
   assign flush           = flush_q;
   assign misaligned      = mis_q;
   assign misaligned_addr = mis_addr_q;
   assign instret         = instret_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit; successor to the combinational pc_adder.
- Holds the architectural PC register.
- Computes the sequential and branch/jump targets.
- Selects the next PC using trap, stall, redirect and misalignment rules.
- Produces a one-cycle flush pulse and an instructions-retired counter.
- Sits at the head of the fetch path; drives the instruction-memory address and feeds the decoder/branch comparator.

Parameters:
- XLEN, 32, datapath/address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- C_EXT, 0, 1 enables 16-bit instruction alignment and +2 increment for compressed instructions.
- CNT_W, 64, width of the instret counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold PC this cycle
- branch_taken  input  1  conditional branch resolved taken
- jump  input  1  JAL/JALR redirect
- jalr  input  1  qualifies jump: target base is rs1, not PC
- rs1  input  XLEN  JALR base register value
- imm  input  XLEN  sign-extended immediate offset
- insn_compressed  input  1  current instruction is 16-bit (ignored when C_EXT=0)
- trap  input  1  exception/interrupt redirect
- trap_target  input  XLEN  trap handler address
- pc_current  output  XLEN  registered PC
- pc_next_seq  output  XLEN  PC + 4, or PC + 2 when compressed
- pc_target  output  XLEN  redirect target
- flush  output  1  one-cycle pulse after a taken redirect or trap
- misaligned  output  1  one-cycle pulse: redirect target misaligned
- misaligned_addr  output  XLEN  offending target, held until the next misalignment
- instret  output  CNT_W  instructions-retired count

Behaviour:
Reset:
- Asynchronous on rst_n low.
- Values: pc_current=RESET_VECTOR, flush=0, misaligned=0, misaligned_addr=0, instret=0.
- Reset mid-operation discards any pending redirect. The first rising edge after deassertion evaluates normally.

Combinational outputs (all arithmetic modulo 2^XLEN, no overflow flag):
- pc_next_seq = pc_current + ((C_EXT && insn_compressed) ? 2 : 4).
- pc_target = jalr ? ((rs1 + imm) & ~1) : (pc_current + imm).

Misaligned target:
- C_EXT=0: pc_target[1:0] != 0.
- C_EXT=1: pc_target[0] != 0.

redir = branch_taken | jump.

Next-state priority on each rising edge, highest first:
1. trap: pc <= trap_target with the low 2 bits forced to 0; flush <= 1; instret unchanged. Trap overrides stall and redirect.
2. stall: pc, instret and misaligned_addr hold; flush <= 0; misaligned <= 0. A redirect presented during stall is dropped; the stage re-presents it.
3. redir with misaligned target: pc holds; misaligned <= 1; misaligned_addr <= pc_target; flush <= 0; instret unchanged.
4. redir with aligned target: pc <= pc_target; flush <= 1; instret += 1.
5. Otherwise: pc <= pc_next_seq; flush <= 0; instret += 1.

Pulse and counter rules:
- flush and misaligned are registered and asserted for exactly one cycle per event. Back-to-back events keep them high on consecutive cycles.
- instret wraps from all-ones to 0.
- pc wraps from all-ones past 0 with no special handling.

Test Plan:
- Reset then 3 free cycles (XLEN=32, RESET_VECTOR=0) -> pc 0,4,8,C; instret=3; flush=0.
- pc=0x20, branch_taken=1, imm=0xFFFFFFF0 -> next pc=0x10; flush=1 for one cycle; instret+1.
- pc=0x40, jump=1, jalr=1, rs1=0x1003, imm=0x4 -> pc_target=0x1006. With C_EXT=0: misaligned=1, misaligned_addr=0x1006, pc stays 0x40. With C_EXT=1: pc=0x1006, flush=1.
- stall=1 for 2 cycles, with branch_taken asserted in the second -> pc and instret frozen, flush=0; after stall drops, pc advances by 4.
- trap=1, trap_target=0x103, with stall=1 and branch_taken=1 -> pc=0x100, flush=1, instret unchanged.
- C_EXT=1, pc=0xFFFFFFFE, insn_compressed=1 -> pc_next_seq=0x0, next pc=0x0. Also preload instret to all-ones and step -> instret=0.
- Assert rst_n low asynchronously mid-cycle during a redirect -> outputs go to reset values immediately, without waiting for a clock edge.
